rf_scoreboard: RTL

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_popcount.sv | 20 ++
 rtl/rf_scoreboard.sv | 103 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rf_pkg -- shared constants for the register-file scoreboard.
//   RF_DW       : default data width
//   RF_AW       : default address width (depth = 2**RF_AW)
//   RF_NRD      : default number of read ports
//   RF_ZERO_IDX : index of the hard-wired zero register
package rf_pkg;
  localparam int RF_DW       = 32;
  localparam int RF_AW       = 5;
  localparam int RF_NRD      = 2;
  localparam int RF_ZERO_IDX = 0;
endpackage

// File: rtl/rf_popcount.sv
// rf_popcount -- combinational population count.
// Ports:
//   i_bits  in  N                 bit vector to count
//   o_count out clog2(N+1)        number of set bits in i_bits
module rf_popcount #(
  parameter  int N  = 32,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  i_bits,
  output logic [CW-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < N; i++) begin
      o_count = o_count + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard -- register file with per-register pending (busy) bits.
// An issue marks a destination register pending; a write-back stores data
// and clears the pending bit. Register 0 is hard-wired to zero and never busy.
// Reads are combinational.
// Configuration macro: RF_BYPASS_EN -- when defined, a read port whose
// address matches an in-flight write-back (wr_en, nonzero wr_addr) returns
// wr_data with rd_busy=0 in the same cycle.
// Ports:
//   clk       in  1        clock, rising edge
//   rst_n     in  1        asynchronous active-low reset
//   wr_en     in  1        write-back strobe
//   wr_addr   in  AW       write-back register index
//   wr_data   in  DW       write-back data
//   iss_en    in  1        issue strobe (sets destination busy)
//   iss_addr  in  AW       issued destination register index
//   rd_addr   in  NRD*AW   packed read addresses, port k at [k*AW +: AW]
//   rd_data   out NRD*DW   packed read data, port k at [k*DW +: DW]
//   rd_busy   out NRD      per-port busy flag
//   busy_cnt  out AW+1     number of registers currently busy
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DW  = RF_DW,
  parameter int AW  = RF_AW,
  parameter int NRD = RF_NRD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  output logic [AW:0]       busy_cnt
);

  localparam int            DEPTH    = 2 ** AW;
  localparam logic [AW-1:0] ZERO_IDX = AW'(RF_ZERO_IDX);

  logic [DW-1:0]    r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             w_wr_hit;
  logic             w_iss_hit;

  assign w_wr_hit  = wr_en  && (wr_addr  != ZERO_IDX);
  assign w_iss_hit = iss_en && (iss_addr != ZERO_IDX);

  // Clear first, then set: a same-address issue and write-back leaves the
  // register busy because the issue belongs to a newer instruction.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_hit) begin
      w_busy_nxt[wr_addr] = 1'b0;
    end
    if (w_iss_hit) begin
      w_busy_nxt[iss_addr] = 1'b1;
    end
    w_busy_nxt[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_busy <= w_busy_nxt;
      if (w_wr_hit) begin
        r_regs[wr_addr] <= wr_data;
      end
    end
  end

  rf_popcount #(.N(DEPTH)) u_popcount (
    .i_bits  (r_busy),
    .o_count (busy_cnt)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_zero;
    logic          w_fwd;

    assign w_ra   = rd_addr[k*AW +: AW];
    assign w_zero = (w_ra == ZERO_IDX);
`ifdef RF_BYPASS_EN
    // Forwarded value is the completed result, so it is never reported busy,
    // even if the same register is re-issued this cycle.
    assign w_fwd  = w_wr_hit && (w_ra == wr_addr);
`else
    assign w_fwd  = 1'b0;
`endif

    assign rd_data[k*DW +: DW] = w_zero ? '0   : (w_fwd ? wr_data : r_regs[w_ra]);
    assign rd_busy[k]          = w_zero ? 1'b0 : (w_fwd ? 1'b0    : r_busy[w_ra]);
  end

endmodule
